// File: rtl/fp16r_to_int16_seq.sv
// Sequential FP16 to int16 converter, truncating toward zero.
// An accepted operand is decoded into a 16-bit magnitude and a shift count.
// The magnitude is shifted one bit per cycle, the sign is applied, and the
// result is held until the consumer takes it.
module fp16r_to_int16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] arg_0,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] ret_0,
    output logic        ret_1,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic        sign_r;
    logic        left_r;
    logic        ovf_r;
    logic [15:0] mag;
    logic [3:0]  cnt;

    logic [4:0]  exp_in;
    logic [9:0]  frac_in;
    logic        accept;

    logic [15:0] mag_init;
    logic [3:0]  cnt_init;
    logic        left_init;
    logic        ovf_init;

    assign exp_in   = arg_0[14:10];
    assign frac_in  = arg_0[9:0];
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Decode the incoming operand into starting magnitude, shift direction,
    // shift count and overflow flag. Saturated results are loaded directly as
    // magnitudes: 0x7FFF with sign 0 passes through the sign stage unchanged,
    // and 0x8000 with sign 1 negates to itself, so the sign stage needs no
    // separate special-case path.
    always_comb begin
        mag_init  = {5'b0, 1'b1, frac_in};
        cnt_init  = 4'd0;
        left_init = 1'b0;
        ovf_init  = 1'b0;
        if (exp_in <= 5'd14) begin
            mag_init = 16'h0000;
        end else if (exp_in <= 5'd24) begin
            cnt_init = 4'(5'd25 - exp_in);
        end else if (exp_in == 5'd25) begin
            cnt_init = 4'd0;
        end else if (exp_in <= 5'd29) begin
            cnt_init  = 4'(exp_in - 5'd25);
            left_init = 1'b1;
        end else if (exp_in == 5'd30) begin
            if (arg_0[15] && (frac_in == 10'd0)) begin
                mag_init = 16'h8000;
            end else begin
                mag_init = arg_0[15] ? 16'h8000 : 16'h7FFF;
                ovf_init = 1'b1;
            end
        end else begin
            ovf_init = 1'b1;
            if (frac_in == 10'd0) begin
                mag_init = arg_0[15] ? 16'h8000 : 16'h7FFF;
            end else begin
                mag_init = 16'h0000;
            end
        end
    end

    // State register, forced to IDLE by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one pass through SHIFT per remaining count, then a
    // single SIGN cycle, then wait in DONE for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt == 4'd0) state_next = SIGN;
            SIGN:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture the operand, shift the magnitude, apply the sign and
    // hold the result until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r    <= 1'b0;
            left_r    <= 1'b0;
            ovf_r     <= 1'b0;
            mag       <= 16'h0000;
            cnt       <= 4'd0;
            ret_0     <= 16'h0000;
            ret_1     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r <= arg_0[15];
                        mag    <= mag_init;
                        cnt    <= cnt_init;
                        left_r <= left_init;
                        ovf_r  <= ovf_init;
                    end
                end
                SHIFT: begin
                    if (cnt != 4'd0) begin
                        mag <= left_r ? (mag << 1) : (mag >> 1);
                        cnt <= cnt - 4'd1;
                    end
                end
                SIGN: begin
                    ret_0     <= sign_r ? (~mag + 16'd1) : mag;
                    ret_1     <= ovf_r;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16r_to_int16_seq.sv
// Testbench for fp16r_to_int16_seq: directed and random operands, expected
// results from an arithmetic reference model pushed to a scoreboard queue,
// and an independent monitor that pops and compares on each new result.
module tb_fp16r_to_int16_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] arg_0 = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ret_0;
    logic        ret_1;
    logic        out_valid;
    logic        out_ready;

    logic        ready_random = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        rand_bit = 1'b1;

    int          edge_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [15:0] r;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fp16r_to_int16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .arg_0     (arg_0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ret_0     (ret_0),
        .ret_1     (ret_1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_ready = ready_random ? rand_bit : ready_fixed;

    // Free-running clock.
    always #5 clk = ~clk;

    // Count active edges so result latency can be measured.
    always @(posedge clk) edge_cnt++;

    // Random consumer back-pressure, changed away from the active edge.
    always @(negedge clk) rand_bit = 1'($urandom_range(0, 1));

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: real-valued conversion done with integer arithmetic,
    // truncated toward zero, then clamped to the int16 range.
    task automatic refModel(input logic [15:0] a, output logic [15:0] r, output logic ovf, output int lat);
        int     e;
        int     f;
        longint m;
        longint v;
        e   = int'(a[14:10]);
        f   = int'(a[9:0]);
        ovf = 1'b0;
        lat = (e >= 15 && e <= 29) ? 2 + ((e > 25) ? e - 25 : 25 - e) : 2;
        if (e == 31 && f != 0) begin
            r   = 16'h0000;
            ovf = 1'b1;
        end else begin
            if (e == 0)
                m = 0;
            else if (e >= 25)
                m = longint'(1024 + f) << (e - 25);
            else
                m = longint'(1024 + f) >> (25 - e);
            v = a[15] ? -m : m;
            if (v > 32767) begin
                v   = 32767;
                ovf = 1'b1;
            end else if (v < -32768) begin
                v   = -32768;
                ovf = 1'b1;
            end
            r = v[15:0];
        end
    endtask

    // Monitor: compare each new result against the scoreboard and check that
    // a held result stays stable while in_ready stays low.
    initial begin
        bit          seen;
        logic [15:0] held_r;
        logic        held_o;
        exp_t        x;
        seen = 1'b0;
        held_r = 16'h0000;
        held_o = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                checkOutput("in_ready_low_while_valid", 32'(in_ready), 32'd0);
                if (!seen) begin
                    seen   = 1'b1;
                    held_r = ret_0;
                    held_o = ret_1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got ret_0=0x%0h with no result pending, required none", ret_0);
                    end else begin
                        x = sb.pop_front();
                        checkOutput("ret_0", 32'(ret_0), 32'(x.r));
                        checkOutput("ret_1", 32'(ret_1), 32'(x.ovf));
                        checkOutput("latency", 32'(edge_cnt - x.acc), 32'(x.lat));
                    end
                end else begin
                    checkOutput("ret_0_stable", 32'(ret_0), 32'(held_r));
                    checkOutput("ret_1_stable", 32'(ret_1), 32'(held_o));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Issue one operand, keep in_valid high with junk data while it is in
    // flight, then wait for the result to be consumed. hold_cycles>0 keeps
    // out_ready low for that many cycles after the result appears.
    task automatic applyStimulus(input logic [15:0] a, input int hold_cycles);
        logic [15:0] r;
        logic        ovf;
        int          lat;
        int          t;
        exp_t        x;
        refModel(a, r, ovf, lat);
        @(negedge clk);
        if (hold_cycles > 0) ready_fixed = 1'b0;
        in_valid = 1'b1;
        arg_0    = a;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            ready_fixed = 1'b1;
            return;
        end
        x.r = r;
        x.ovf = ovf;
        x.lat = lat;
        x.acc = edge_cnt + 1;
        sb.push_back(x);
        @(posedge clk);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            arg_0    = 16'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            checkOutput("result_timeout", 32'(out_valid), 32'd1);
            ready_fixed = 1'b1;
            return;
        end
        if (hold_cycles > 0) begin
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            end
            ready_fixed = 1'b1;
            @(negedge clk);
            checkOutput("consumed_out_valid", 32'(out_valid), 32'd0);
            checkOutput("consumed_in_ready", 32'(in_ready), 32'd1);
        end
        t = 0;
        while (out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (out_valid) checkOutput("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    // Main sequence: reset, directed cases, back-pressure, reset abort, random.
    initial begin
        logic [15:0] directed [14];
        directed = '{16'h3C00, 16'hC900, 16'h3800, 16'h7800, 16'hF800, 16'h7E00, 16'hFC00,
                     16'h7BFF, 16'h77FF, 16'h0000, 16'h8000, 16'h0001, 16'hBC00, 16'h6400};

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_ret_0", 32'(ret_0), 32'd0);
        checkOutput("reset_ret_1", 32'(ret_1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        foreach (directed[i]) applyStimulus(directed[i], 0);

        applyStimulus(16'hC900, 5);

        // Abort a conversion of 1.0 by resetting on its third SHIFT edge.
        @(negedge clk);
        in_valid = 1'b1;
        arg_0    = 16'h3C00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_ret_0", 32'(ret_0), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_release_in_ready", 32'(in_ready), 32'd1);
        repeat (15) @(negedge clk);
        checkOutput("abort_no_output", 32'(out_valid), 32'd0);
        applyStimulus(16'h4500, 0);

        ready_random = 1'b1;
        repeat (150) applyStimulus(16'($urandom), 0);
        ready_random = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
